inst_mem: RTL

INST_MEM -- requirements
Module: inst_mem

---
 rtl/inst_mem_pkg.sv | 28 ++
 rtl/inst_mem_byte_packer.sv | 36 +++
 rtl/inst_mem.sv | 100 ++++++++++
 3 files changed

// File: rtl/inst_mem_pkg.sv
// Shared CPU defines: datapath widths, NOP encoding, loader FSM states
// and the opcode constants used by the decode stage.
package inst_mem_pkg;

  localparam int INST_W = 32;
  localparam int BYTE_W = 8;

  localparam logic [INST_W-1:0] NOP = 32'h0000_0000;

  typedef enum logic {
    IDLE = 1'b0,
    LOAD = 1'b1
  } load_state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

endpackage

// File: rtl/inst_mem_byte_packer.sv
// Assembles serial program bytes into big-endian 32-bit words and flags
// the edge on which the fourth byte completes a word.
module byte_packer
  import inst_mem_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  input  logic              clear,
  input  logic              accept,
  input  logic [BYTE_W-1:0] byte_in,
  output logic              word_valid,
  output logic [INST_W-1:0] word
);

  logic [1:0]        count;
  logic [INST_W-1:0] shift;

  // The first byte shifts all the way up to [31:24] by the time the
  // fourth arrives; clear drops any partial word on session open/close.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= 2'd0;
      shift <= '0;
    end else if (clear) begin
      count <= 2'd0;
      shift <= '0;
    end else if (accept) begin
      count <= count + 2'd1;
      shift <= {shift[INST_W-BYTE_W-1:0], byte_in};
    end
  end

  assign word_valid = accept && (count == 2'd3);
  assign word       = {shift[INST_W-BYTE_W-1:0], byte_in};

endmodule

// File: rtl/inst_mem.sv
// Instruction memory with zero-latency fetch and a serial byte loader that
// stalls fetch while a program image is being written.
module inst_mem
  import inst_mem_pkg::*;
#(
  parameter int DEPTH_LOG2 = 8
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  ce,
  input  logic [31:0]           addr,
  output logic [INST_W-1:0]     inst,
  output logic                  fetch_stall,
  output logic                  misalign,
  input  logic                  load_start,
  input  logic                  load_valid,
  input  logic [BYTE_W-1:0]     load_byte,
  output logic                  load_ready,
  output logic                  load_done,
  output logic [DEPTH_LOG2:0]   words_loaded,
  output logic                  overflow
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  load_state_t           state;
  logic [DEPTH_LOG2-1:0] wptr;
  logic [INST_W-1:0]     mem [DEPTH];
  logic                  word_valid;
  logic [INST_W-1:0]     word;
  logic                  accept;
  logic                  unused_addr_bits;

  assign load_ready  = (state == LOAD) && !load_start;
  assign accept      = load_valid && load_ready;
  assign fetch_stall = (state == LOAD);
  assign misalign    = ce && (addr[1:0] != 2'b00);

  assign unused_addr_bits = ^{addr[31:DEPTH_LOG2+2], addr[1:0]};

  byte_packer u_packer (
    .clk        (clk),
    .reset_n    (reset_n),
    .clear      (load_start),
    .accept     (accept),
    .byte_in    (load_byte),
    .word_valid (word_valid),
    .word       (word)
  );

  // Session control; words_loaded only ever reaches its top bit at the
  // saturation value, so that bit alone gates further increments.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      wptr         <= '0;
      words_loaded <= '0;
      overflow     <= 1'b0;
      load_done    <= 1'b0;
    end else begin
      load_done <= 1'b0;
      case (state)
        IDLE: begin
          if (load_start) begin
            state        <= LOAD;
            wptr         <= '0;
            words_loaded <= '0;
            overflow     <= 1'b0;
          end
        end
        LOAD: begin
          if (load_start) begin
            state     <= IDLE;
            load_done <= 1'b1;
          end else if (word_valid) begin
            wptr <= wptr + 1'b1;
            if (&wptr)
              overflow <= 1'b1;
            if (!words_loaded[DEPTH_LOG2])
              words_loaded <= words_loaded + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Storage is deliberately left out of reset so a program survives it.
  always_ff @(posedge clk) begin
    if (word_valid)
      mem[wptr] <= word;
  end

  always_comb begin
    inst = NOP;
    if (ce && state == IDLE)
      inst = mem[addr[DEPTH_LOG2+1:2]];
  end

endmodule
